// File: rtl/apb_s_if.sv
// apb_s_if: APB bus between apb_m (master) and apb_s (slave).
//   psel/penable/pwrite/paddr/pwdata : master -> slave
//   prdata/pready/pslverr            : slave -> master
interface apb_s_if #(parameter int ADDR_W = 4, parameter int DATA_W = 8);
  logic psel;
  logic penable;
  logic pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [DATA_W-1:0] pwdata;
  logic [DATA_W-1:0] prdata;
  logic pready;
  logic pslverr;
  modport master (output psel, penable, pwrite, paddr, pwdata, input prdata, pready, pslverr);
  modport slave (input psel, penable, pwrite, paddr, pwdata, output prdata, pready, pslverr);
endinterface

// File: rtl/apb_s.sv
// apb_s: APB slave backed by a DEPTH-entry register bank with WAIT_CYCLES wait states.
//   pclk    : clock, all state on rising edge
//   presetn : asynchronous active-low reset, clears FSM, outputs and register bank
//   bus     : apb_s_if slave modport (prdata/pready/pslverr registered, zero unless pready)
module apb_s #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 8,
  parameter int DEPTH = 16,
  parameter int WAIT_CYCLES = 0
) (
  input logic pclk,
  input logic presetn,
  apb_s_if.slave bus
);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);
  typedef enum logic {IDLE, ACCESS} state_t;
  state_t state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d, ra;
  logic [DATA_W-1:0] wd_q, wd_d, rdat, prdata_d;
  logic wr_q, wr_d, rw, rlegal, pready_d, pslverr_d, we;
  logic [DATA_W-1:0] bank [DEPTH];
  // The response is formed at the setup edge from the live bus when there are no
  // wait states, otherwise from the copies captured at setup.
  assign ra = state == IDLE ? bus.paddr : addr_q;
  assign rw = state == IDLE ? bus.pwrite : wr_q;
  assign rlegal = {1'b0, ra} < DEPTH_L;
  assign rdat = rlegal && !rw ? bank[ra] : '0;
  always_comb begin
    state_d = state;
    cnt_d = cnt;
    addr_d = addr_q;
    wr_d = wr_q;
    wd_d = wd_q;
    pready_d = bus.pready;
    prdata_d = bus.prdata;
    pslverr_d = bus.pslverr;
    we = 1'b0;
    if (state == IDLE) begin
      if (bus.psel && !bus.penable) begin
        state_d = ACCESS;
        cnt_d = 4'(WAIT_CYCLES);
        addr_d = bus.paddr;
        wr_d = bus.pwrite;
        wd_d = bus.pwdata;
        if (WAIT_CYCLES == 0) {pready_d, prdata_d, pslverr_d} = {1'b1, rdat, !rlegal};
      end
    end else if (!bus.psel) begin
      state_d = IDLE;
      {pready_d, prdata_d, pslverr_d} = '0;
    end else if (bus.penable) begin
      if (bus.pready) begin
        we = wr_q && rlegal;
        state_d = IDLE;
        {pready_d, prdata_d, pslverr_d} = '0;
      end else begin
        cnt_d = cnt - 4'd1;
        if (cnt == 4'd1) {pready_d, prdata_d, pslverr_d} = {1'b1, rdat, !rlegal};
      end
    end
  end
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state <= IDLE;
      cnt <= '0;
      addr_q <= '0;
      wr_q <= 1'b0;
      wd_q <= '0;
      bus.prdata <= '0;
      bus.pready <= 1'b0;
      bus.pslverr <= 1'b0;
      for (int i = 0; i < DEPTH; i++) bank[i] <= '0;
    end else begin
      state <= state_d;
      cnt <= cnt_d;
      addr_q <= addr_d;
      wr_q <= wr_d;
      wd_q <= wd_d;
      bus.prdata <= prdata_d;
      bus.pready <= pready_d;
      bus.pslverr <= pslverr_d;
      if (we) bank[addr_q] <= wd_q;
    end
  end
endmodule

// File: tb/tb_apb_s.sv
// tb_apb_s: directed checks of apb_s across wait-state and depth configurations.
module tb_apb_s;
  logic pclk = 1'b0;
  logic presetn = 1'b0;
  logic psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [3:0] paddr = '0;
  logic [7:0] pwdata = '0;
  int sel = 0;
  int total = 0;
  int passed = 0;
  logic [7:0] rd;
  logic rdy, err;
  always #5 pclk = ~pclk;
  apb_s_if #(.ADDR_W(4), .DATA_W(8)) b0 ();
  apb_s_if #(.ADDR_W(4), .DATA_W(8)) b1 ();
  apb_s_if #(.ADDR_W(4), .DATA_W(8)) b2 ();
  apb_s_if #(.ADDR_W(4), .DATA_W(8)) b3 ();
  assign {b0.psel, b0.penable, b0.pwrite, b0.paddr, b0.pwdata} = {psel, penable, pwrite, paddr, pwdata};
  assign {b1.psel, b1.penable, b1.pwrite, b1.paddr, b1.pwdata} = {psel, penable, pwrite, paddr, pwdata};
  assign {b2.psel, b2.penable, b2.pwrite, b2.paddr, b2.pwdata} = {psel, penable, pwrite, paddr, pwdata};
  assign {b3.psel, b3.penable, b3.pwrite, b3.paddr, b3.pwdata} = {psel, penable, pwrite, paddr, pwdata};
  apb_s #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(0)) u0 (.pclk(pclk), .presetn(presetn), .bus(b0));
  apb_s #(.ADDR_W(4), .DATA_W(8), .DEPTH(12), .WAIT_CYCLES(0)) u1 (.pclk(pclk), .presetn(presetn), .bus(b1));
  apb_s #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(2)) u2 (.pclk(pclk), .presetn(presetn), .bus(b2));
  apb_s #(.ADDR_W(4), .DATA_W(8), .DEPTH(16), .WAIT_CYCLES(3)) u3 (.pclk(pclk), .presetn(presetn), .bus(b3));
  always_comb begin
    rd = sel == 0 ? b0.prdata : sel == 1 ? b1.prdata : sel == 2 ? b2.prdata : b3.prdata;
    rdy = sel == 0 ? b0.pready : sel == 1 ? b1.pready : sel == 2 ? b2.pready : b3.pready;
    err = sel == 0 ? b0.pslverr : sel == 1 ? b1.pslverr : sel == 2 ? b2.pslverr : b3.pslverr;
  end
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, " pready"}, {7'd0, rdy}, 8'h00);
    chk({tag, " prdata"}, rd, 8'h00);
    chk({tag, " pslverr"}, {7'd0, err}, 8'h00);
  endtask
  task automatic reset_to(input int s);
    sel = s;
    presetn = 1'b0;
    psel = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    @(negedge pclk);
    presetn = 1'b1;
    chk_zero("reset");
  endtask
  // Setup then access; address/data/direction are scrambled during access so
  // only the values captured at setup can produce the expected result.
  task automatic xfer(input logic w, input logic [3:0] a, input logic [7:0] d, input int waits,
                      input logic [7:0] exp_rd, input logic exp_err, input string tag);
    @(negedge pclk);
    {psel, penable, pwrite, paddr, pwdata} = {1'b1, 1'b0, w, a, d};
    @(negedge pclk);
    {penable, pwrite, paddr, pwdata} = {1'b1, ~w, ~a, ~d};
    for (int i = 0; i < waits; i++) begin
      chk({tag, " wait"}, {7'd0, rdy}, 8'h00);
      @(negedge pclk);
    end
    chk({tag, " pready"}, {7'd0, rdy}, 8'h01);
    chk({tag, " pslverr"}, {7'd0, err}, {7'd0, exp_err});
    if (!w) chk({tag, " prdata"}, rd, exp_rd);
  endtask
  task automatic idle(input string tag);
    @(negedge pclk);
    psel = 1'b0;
    penable = 1'b0;
    chk_zero(tag);
  endtask
  initial begin
    reset_to(0);
    @(negedge pclk);
    {psel, penable, paddr} = {1'b1, 1'b1, 4'd3};
    @(negedge pclk);
    chk("penable w/o setup 1", {7'd0, rdy}, 8'h00);
    @(negedge pclk);
    chk("penable w/o setup 2", {7'd0, rdy}, 8'h00);
    psel = 1'b0;
    penable = 1'b0;
    xfer(1'b1, 4'd3, 8'h5a, 0, 8'h00, 1'b0, "w0 wr3");
    xfer(1'b0, 4'd3, 8'h00, 0, 8'h5a, 1'b0, "w0 rd3");
    idle("w0 close");
    xfer(1'b1, 4'd1, 8'h11, 0, 8'h00, 1'b0, "b2b wr1");
    xfer(1'b1, 4'd2, 8'h22, 0, 8'h00, 1'b0, "b2b wr2");
    xfer(1'b0, 4'd1, 8'h00, 0, 8'h11, 1'b0, "b2b rd1");
    xfer(1'b0, 4'd2, 8'h00, 0, 8'h22, 1'b0, "b2b rd2");
    idle("b2b close");
    reset_to(1);
    xfer(1'b1, 4'd12, 8'hff, 0, 8'h00, 1'b1, "d12 wr12");
    xfer(1'b0, 4'd12, 8'h00, 0, 8'h00, 1'b1, "d12 rd12");
    xfer(1'b0, 4'd11, 8'h00, 0, 8'h00, 1'b0, "d12 rd11");
    xfer(1'b0, 4'd3, 8'h00, 0, 8'h00, 1'b0, "d12 rd3");
    idle("d12 close");
    reset_to(2);
    xfer(1'b0, 4'd0, 8'h00, 2, 8'h00, 1'b0, "w2 rd0");
    idle("w2 close");
    xfer(1'b1, 4'd4, 8'h44, 2, 8'h00, 1'b0, "w2 wr4");
    @(negedge pclk);
    {psel, penable, pwrite, paddr, pwdata} = {1'b1, 1'b0, 1'b1, 4'd4, 8'h77};
    @(negedge pclk);
    penable = 1'b1;
    chk("abort wait1", {7'd0, rdy}, 8'h00);
    @(negedge pclk);
    chk("abort wait2", {7'd0, rdy}, 8'h00);
    psel = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    chk_zero("abort after");
    xfer(1'b0, 4'd4, 8'h00, 2, 8'h44, 1'b0, "abort rd4");
    idle("abort close");
    reset_to(3);
    @(negedge pclk);
    {psel, penable, pwrite, paddr, pwdata} = {1'b1, 1'b0, 1'b1, 4'd5, 8'ha5};
    @(negedge pclk);
    penable = 1'b1;
    chk("w3 wait1", {7'd0, rdy}, 8'h00);
    @(negedge pclk);
    chk("w3 wait2", {7'd0, rdy}, 8'h00);
    #2 presetn = 1'b0;
    #1 chk_zero("w3 rst mid");
    psel = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    xfer(1'b0, 4'd5, 8'h00, 3, 8'h00, 1'b0, "w3 rd5");
    xfer(1'b1, 4'd6, 8'h99, 3, 8'h00, 1'b0, "w3 wr6");
    xfer(1'b0, 4'd6, 8'h00, 3, 8'h99, 1'b0, "w3 rd6");
    #2 presetn = 1'b0;
    #1 chk_zero("w3 rst async");
    psel = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    presetn = 1'b1;
    xfer(1'b0, 4'd6, 8'h00, 3, 8'h00, 1'b0, "w3 rd6 cleared");
    idle("w3 close");
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
